// File: rtl/serial_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// serial_arb_pkg
// Shared definitions for the serial arbiter slice:
//   - default widths used by the interface and the top level
//   - t_arb_state : arbiter FSM states
//   - rr_pick()   : cyclic first-requester-at-or-after-pointer select, one-hot
// ---------------------------------------------------------------------------
package serial_arb_pkg;

    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_BITS      = 8;
    localparam int DEF_WORDS_MAX = 16;

    // rr_pick works on a fixed-width scratch vector so one function serves
    // every NUM_REQ; NUM_REQ must stay below RR_MAX_REQ.
    localparam int RR_MAX_REQ  = 32;
    localparam int RR_IDX_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN,
        DONE
    } t_arb_state;

    // Walks the requesters starting at ptr and wrapping at n; the first one
    // found requesting wins. Bits at or above n are never set.
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0]  req,
        input logic [RR_IDX_BITS-1:0] ptr,
        input logic [RR_IDX_BITS:0]   n
    );
        logic [RR_MAX_REQ-1:0]  onehot;
        logic                   found;
        logic [RR_IDX_BITS:0]   idx;
        onehot = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < RR_MAX_REQ; k++) begin
            idx = {1'b0, ptr} + (RR_IDX_BITS + 1)'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (((RR_IDX_BITS + 1)'(k) < n) && !found && req[idx[RR_IDX_BITS-1:0]]) begin
                onehot[idx[RR_IDX_BITS-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/serial_arbiter_if.sv
// ---------------------------------------------------------------------------
// serial_arbiter_if
// Bundles the requester side and the serial-controller side of the arbiter.
//   in_req / in_len / in_data       : per-requester request, word count, tx word
//   out_grant / out_next / out_done : per-requester grant, word-consumed, finished
//   out_rxdata / out_rxvalid        : received word to the granted requester
//   out_ser_enable / out_ser_parallel, in_ser_next / in_ser_ready /
//   in_ser_parallel                 : serial controller handshake and data
// master = the arbiter, slave = requesters plus serial controller.
// ---------------------------------------------------------------------------
interface serial_arbiter_if
    import serial_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int BITS     = DEF_BITS,
    parameter int LEN_BITS = $clog2(DEF_WORDS_MAX + 1)
);

    logic [NUM_REQ-1:0]          in_req;
    logic [NUM_REQ*LEN_BITS-1:0] in_len;
    logic [NUM_REQ*BITS-1:0]     in_data;
    logic [NUM_REQ-1:0]          out_grant;
    logic [NUM_REQ-1:0]          out_next;
    logic [NUM_REQ-1:0]          out_done;
    logic [BITS-1:0]             out_rxdata;
    logic                        out_rxvalid;
    logic                        out_ser_enable;
    logic [BITS-1:0]             out_ser_parallel;
    logic                        in_ser_next;
    logic                        in_ser_ready;
    logic [BITS-1:0]             in_ser_parallel;

    modport master (
        input  in_req, in_len, in_data, in_ser_next, in_ser_ready, in_ser_parallel,
        output out_grant, out_next, out_done, out_rxdata, out_rxvalid,
               out_ser_enable, out_ser_parallel
    );

    modport slave (
        output in_req, in_len, in_data, in_ser_next, in_ser_ready, in_ser_parallel,
        input  out_grant, out_next, out_done, out_rxdata, out_rxvalid,
               out_ser_enable, out_ser_parallel
    );

endinterface

// File: rtl/serial_arbiter_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin select.
//   req   in  NUM_REQ   request vector
//   ptr   in  PTR_BITS  index that has priority this round
//   grant out NUM_REQ   one-hot winner, all zero when nobody requests
// ---------------------------------------------------------------------------
module rr_picker
    import serial_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int PTR_BITS = 1
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [PTR_BITS-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant
);

    localparam logic [RR_IDX_BITS:0] REQ_COUNT = (RR_IDX_BITS + 1)'(NUM_REQ);

    logic [RR_MAX_REQ-1:0] pick_full;
    logic                  unused_pick_hi;

    assign pick_full = rr_pick(RR_MAX_REQ'(req), RR_IDX_BITS'(ptr), REQ_COUNT);
    assign grant     = pick_full[NUM_REQ-1:0];

    // rr_pick never sets bits at or above NUM_REQ
    assign unused_pick_hi = ^pick_full[RR_MAX_REQ-1:NUM_REQ];

endmodule

// File: rtl/serial_arbiter.sv
// ---------------------------------------------------------------------------
// serial_arbiter
// Shares one serial controller between NUM_REQ requesters doing multi-word
// transfers. Round-robin grant, serial enable held for exactly the requested
// word count, tx data steered from the granted requester, rx words returned.
//   in_clk  in  system clock
//   in_rst  in  asynchronous active-high reset
//   bus     serial_arbiter_if.master (requester and serial-controller signals)
// ---------------------------------------------------------------------------
module serial_arbiter
    import serial_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int BITS      = DEF_BITS,
    parameter int WORDS_MAX = DEF_WORDS_MAX,
    parameter int LEN_BITS  = $clog2(WORDS_MAX + 1)
) (
    input  logic             in_clk,
    input  logic             in_rst,
    serial_arbiter_if.master bus
);

    localparam int                  PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [LEN_BITS-1:0] LEN_MAX  = LEN_BITS'(WORDS_MAX);

    t_arb_state          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  next_q, next_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] count_q, count_d;
    logic [PTR_BITS-1:0] ptr_q, ptr_d;
    logic [BITS-1:0]     rxdata_q, rxdata_d;
    logic                rxvalid_q, rxvalid_d;
    logic                enable_q, enable_d;

    logic [NUM_REQ-1:0]  pick;
    logic [LEN_BITS-1:0] pick_len_raw;
    logic [LEN_BITS-1:0] pick_len;
    logic [PTR_BITS-1:0] pick_next_ptr;
    logic [LEN_BITS-1:0] count_inc;
    logic [BITS-1:0]     ser_parallel;

    rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .PTR_BITS (PTR_BITS)
    ) u_picker (
        .req   (bus.in_req),
        .ptr   (ptr_q),
        .grant (pick)
    );

    // Length and follow-on pointer of the requester the picker would choose.
    // Oversized lengths clamp to WORDS_MAX so the counter can never wrap.
    always_comb begin
        pick_len_raw  = '0;
        pick_next_ptr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_len_raw  = bus.in_len[i*LEN_BITS +: LEN_BITS];
                pick_next_ptr = (i == NUM_REQ - 1) ? '0 : PTR_BITS'(i + 1);
            end
        end
        pick_len = (pick_len_raw > LEN_MAX) ? LEN_MAX : pick_len_raw;
    end

    assign count_inc = count_q + LEN_BITS'(1);

    // Next-state and next-output logic. Pulses default to zero so they only
    // last one cycle; everything else holds unless a state acts on it.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        len_d     = len_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        rxdata_d  = rxdata_q;
        enable_d  = enable_q;
        next_d    = '0;
        done_d    = '0;
        rxvalid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if ((|bus.in_req) && bus.in_ser_ready) begin
                    grant_d = pick;
                    len_d   = pick_len;
                    count_d = '0;
                    ptr_d   = pick_next_ptr;
                    if (pick_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = XFER;
                        enable_d = 1'b1;
                    end
                end
            end
            XFER: begin
                if (bus.in_ser_next) begin
                    count_d   = count_inc;
                    next_d    = grant_q;
                    rxvalid_d = 1'b1;
                    rxdata_d  = bus.in_ser_parallel;
                    if (count_inc == len_q) begin
                        enable_d = 1'b0;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.in_ser_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = grant_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops the enable and all pulses at once.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            next_q    <= '0;
            done_q    <= '0;
            len_q     <= '0;
            count_q   <= '0;
            ptr_q     <= '0;
            rxdata_q  <= '0;
            rxvalid_q <= 1'b0;
            enable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            next_q    <= next_d;
            done_q    <= done_d;
            len_q     <= len_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            rxdata_q  <= rxdata_d;
            rxvalid_q <= rxvalid_d;
            enable_q  <= enable_d;
        end
    end

    // Tx word mux driven by the registered grant; zero when nobody is granted.
    always_comb begin
        ser_parallel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                ser_parallel = bus.in_data[i*BITS +: BITS];
            end
        end
    end

    assign bus.out_grant        = grant_q;
    assign bus.out_next         = next_q;
    assign bus.out_done         = done_q;
    assign bus.out_rxdata       = rxdata_q;
    assign bus.out_rxvalid      = rxvalid_q;
    assign bus.out_ser_enable   = enable_q;
    assign bus.out_ser_parallel = ser_parallel;

endmodule

// File: tb/tb_serial_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serial_arbiter
// Directed bench for serial_arbiter with a behavioural serial controller in
// loopback: each word takes 11 clocks, the word sent comes back as rx data.
// ---------------------------------------------------------------------------
module tb_serial_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int BITS      = 8;
    localparam int WORDS_MAX = 16;
    localparam int LEN_BITS  = 5;

    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    int n_next [NUM_REQ] = '{default: 0};
    int n_done [NUM_REQ] = '{default: 0};
    int n_rxvalid = 0;
    int n_rxbad   = 0;
    int n_enable  = 0;

    logic [NUM_REQ-1:0] glog [64];
    int                 gcount = 0;
    logic [NUM_REQ-1:0] prev_grant = '0;
    logic [BITS-1:0]    exp_rx = '0;

    int b_next0, b_next1, b_done0, b_done1, b_rxv, b_rxbad, b_en, b_glog;

    logic            m_busy;
    logic [3:0]      m_cnt;
    logic [BITS-1:0] m_shreg;

    serial_arbiter_if #(
        .NUM_REQ  (NUM_REQ),
        .BITS     (BITS),
        .LEN_BITS (LEN_BITS)
    ) bus ();

    serial_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .BITS      (BITS),
        .WORDS_MAX (WORDS_MAX),
        .LEN_BITS  (LEN_BITS)
    ) dut (
        .in_clk (clk),
        .in_rst (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial controller model: latch the word when enabled, pulse next after
    // 8 clocks with the same word looped back, then at clock 10 either take
    // the following word or fall idle and raise ready.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy              <= 1'b0;
            m_cnt               <= '0;
            m_shreg             <= '0;
            bus.in_ser_next     <= 1'b0;
            bus.in_ser_ready    <= 1'b1;
            bus.in_ser_parallel <= '0;
        end else begin
            bus.in_ser_next <= 1'b0;
            if (!m_busy) begin
                if (bus.out_ser_enable) begin
                    m_busy           <= 1'b1;
                    m_cnt            <= '0;
                    m_shreg          <= bus.out_ser_parallel;
                    bus.in_ser_ready <= 1'b0;
                end
            end else begin
                m_cnt <= m_cnt + 4'd1;
                if (m_cnt == 4'd7) begin
                    bus.in_ser_next     <= 1'b1;
                    bus.in_ser_parallel <= m_shreg;
                end
                if (m_cnt == 4'd10) begin
                    m_cnt <= '0;
                    if (bus.out_ser_enable) begin
                        m_shreg <= bus.out_ser_parallel;
                    end else begin
                        m_busy           <= 1'b0;
                        bus.in_ser_ready <= 1'b1;
                    end
                end
            end
        end
    end

    // Running event counters and grant history, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.out_next[i]) n_next[i]++;
            if (bus.out_done[i]) n_done[i]++;
        end
        if (bus.out_rxvalid) begin
            n_rxvalid++;
            if (bus.out_rxdata !== exp_rx) n_rxbad++;
        end
        if (bus.out_ser_enable) n_enable++;
        if ((bus.out_grant !== prev_grant) && (bus.out_grant != '0) && (gcount < 64)) begin
            glog[gcount] = bus.out_grant;
            gcount++;
        end
        prev_grant = bus.out_grant;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic req,
                                 input logic [LEN_BITS-1:0] len, input logic [BITS-1:0] data);
        bus.in_req[idx]                      = req;
        bus.in_len[idx*LEN_BITS +: LEN_BITS] = len;
        bus.in_data[idx*BITS +: BITS]        = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    task automatic snapshot();
        b_next0 = n_next[0];
        b_next1 = n_next[1];
        b_done0 = n_done[0];
        b_done1 = n_done[1];
        b_rxv   = n_rxvalid;
        b_rxbad = n_rxbad;
        b_en    = n_enable;
        b_glog  = gcount;
    endtask

    task automatic waitDone(input int idx, input int budget, input string tag);
        int   base;
        logic seen;
        base = n_done[idx];
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            #1;
            if (n_done[idx] != base) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic waitNext(input int idx, input int budget, input string tag);
        int   base;
        logic seen;
        base = n_next[idx];
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            #1;
            if (n_next[idx] != base) seen = 1'b1;
        end
        checkOutput({tag, "_next_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        bus.in_req  = '0;
        bus.in_len  = '0;
        bus.in_data = '0;
        tick(3);

        $display("[TB] reset state");
        checkOutput("rst_grant",    32'(bus.out_grant),        32'h0);
        checkOutput("rst_enable",   32'(bus.out_ser_enable),   32'h0);
        checkOutput("rst_next",     32'(bus.out_next),         32'h0);
        checkOutput("rst_done",     32'(bus.out_done),         32'h0);
        checkOutput("rst_rxvalid",  32'(bus.out_rxvalid),      32'h0);
        checkOutput("rst_rxdata",   32'(bus.out_rxdata),       32'h0);
        checkOutput("rst_parallel", 32'(bus.out_ser_parallel), 32'h0);
        rst = 1'b0;
        tick(2);

        $display("[TB] single transfer");
        snapshot();
        exp_rx = 8'hA5;
        applyStimulus(0, 1'b1, 5'd3, 8'hA5);
        tick(1);
        checkOutput("t1_grant",    32'(bus.out_grant),        32'h1);
        checkOutput("t1_enable",   32'(bus.out_ser_enable),   32'h1);
        checkOutput("t1_parallel", 32'(bus.out_ser_parallel), 32'hA5);
        applyStimulus(0, 1'b0, 5'd3, 8'hA5);
        waitDone(0, 100, "t1");
        tick(3);
        checkOutput("t1_next_cnt",    32'(n_next[0] - b_next0), 32'd3);
        checkOutput("t1_other_next",  32'(n_next[1] - b_next1), 32'd0);
        checkOutput("t1_rxvalid_cnt", 32'(n_rxvalid - b_rxv),   32'd3);
        checkOutput("t1_rxdata_bad",  32'(n_rxbad - b_rxbad),   32'd0);
        checkOutput("t1_done_cnt",    32'(n_done[0] - b_done0), 32'd1);
        checkOutput("t1_enable_after", 32'(bus.out_ser_enable), 32'h0);
        checkOutput("t1_grant_after",  32'(bus.out_grant),      32'h0);

        $display("[TB] round robin");
        snapshot();
        exp_rx = 8'h5A;
        applyStimulus(1, 1'b1, 5'd1, 8'h5A);
        tick(1);
        checkOutput("t2_grant_first", 32'(bus.out_grant), 32'h2);
        applyStimulus(1, 1'b0, 5'd1, 8'h5A);
        waitDone(1, 100, "t2a");
        tick(2);
        applyStimulus(0, 1'b1, 5'd1, 8'h5A);
        applyStimulus(1, 1'b1, 5'd1, 8'h5A);
        waitDone(0, 100, "t2b");
        waitDone(1, 100, "t2c");
        applyStimulus(0, 1'b0, 5'd1, 8'h5A);
        applyStimulus(1, 1'b0, 5'd1, 8'h5A);
        tick(3);
        checkOutput("t2_grant_count", 32'(gcount - b_glog), 32'd3);
        checkOutput("t2_order_0", 32'(glog[b_glog]),     32'h2);
        checkOutput("t2_order_1", 32'(glog[b_glog + 1]), 32'h1);
        checkOutput("t2_order_2", 32'(glog[b_glog + 2]), 32'h2);
        checkOutput("t2_rxdata_bad", 32'(n_rxbad - b_rxbad), 32'd0);

        $display("[TB] zero length");
        snapshot();
        applyStimulus(0, 1'b1, 5'd0, 8'hA5);
        tick(1);
        checkOutput("t3_grant",   32'(bus.out_grant),      32'h1);
        checkOutput("t3_done_e1", 32'(bus.out_done),       32'h0);
        checkOutput("t3_enable",  32'(bus.out_ser_enable), 32'h0);
        applyStimulus(0, 1'b0, 5'd0, 8'hA5);
        tick(1);
        checkOutput("t3_done_e2",  32'(bus.out_done),  32'h1);
        checkOutput("t3_grant_e2", 32'(bus.out_grant), 32'h0);
        tick(1);
        checkOutput("t3_done_e3",    32'(bus.out_done),         32'h0);
        checkOutput("t3_enable_cnt", 32'(n_enable - b_en),      32'd0);
        checkOutput("t3_next_cnt",   32'(n_next[0] - b_next0),  32'd0);
        tick(2);

        $display("[TB] abort by reset");
        exp_rx = 8'h3C;
        applyStimulus(1, 1'b1, 5'd4, 8'h3C);
        tick(1);
        checkOutput("t4_grant", 32'(bus.out_grant), 32'h2);
        applyStimulus(1, 1'b0, 5'd4, 8'h3C);
        waitNext(1, 100, "t4");
        snapshot();
        rst = 1'b1;
        #1;
        checkOutput("t4_rst_enable",  32'(bus.out_ser_enable), 32'h0);
        checkOutput("t4_rst_grant",   32'(bus.out_grant),      32'h0);
        checkOutput("t4_rst_next",    32'(bus.out_next),       32'h0);
        checkOutput("t4_rst_rxvalid", 32'(bus.out_rxvalid),    32'h0);
        checkOutput("t4_rst_rxdata",  32'(bus.out_rxdata),     32'h0);
        tick(2);
        rst = 1'b0;
        tick(3);
        checkOutput("t4_no_done", 32'(n_done[1] - b_done1), 32'd0);
        snapshot();
        applyStimulus(1, 1'b1, 5'd4, 8'h3C);
        tick(1);
        checkOutput("t4_regrant", 32'(bus.out_grant), 32'h2);
        applyStimulus(1, 1'b0, 5'd4, 8'h3C);
        waitDone(1, 150, "t4");
        tick(2);
        checkOutput("t4_next_cnt",    32'(n_next[1] - b_next1), 32'd4);
        checkOutput("t4_rxvalid_cnt", 32'(n_rxvalid - b_rxv),   32'd4);
        checkOutput("t4_rxdata_bad",  32'(n_rxbad - b_rxbad),   32'd0);

        $display("[TB] request dropped");
        snapshot();
        exp_rx = 8'hA5;
        applyStimulus(0, 1'b1, 5'd2, 8'hA5);
        tick(1);
        checkOutput("t5_grant", 32'(bus.out_grant), 32'h1);
        applyStimulus(0, 1'b0, 5'd2, 8'hA5);
        waitDone(0, 100, "t5");
        tick(2);
        checkOutput("t5_next_cnt", 32'(n_next[0] - b_next0), 32'd2);
        checkOutput("t5_done_cnt", 32'(n_done[0] - b_done0), 32'd1);

        $display("[TB] length limits");
        snapshot();
        applyStimulus(0, 1'b1, 5'd16, 8'hA5);
        tick(1);
        applyStimulus(0, 1'b0, 5'd16, 8'hA5);
        waitDone(0, 400, "t6a");
        tick(2);
        checkOutput("t6_max_next",    32'(n_next[0] - b_next0), 32'd16);
        checkOutput("t6_max_rxvalid", 32'(n_rxvalid - b_rxv),   32'd16);
        snapshot();
        applyStimulus(0, 1'b1, 5'd31, 8'hA5);
        tick(1);
        applyStimulus(0, 1'b0, 5'd31, 8'hA5);
        waitDone(0, 400, "t6b");
        tick(2);
        checkOutput("t6_sat_next",   32'(n_next[0] - b_next0), 32'd16);
        checkOutput("t6_sat_done",   32'(n_done[0] - b_done0), 32'd1);
        checkOutput("t6_rxdata_bad", 32'(n_rxbad - b_rxbad),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
